// File: rtl/cpu_pio_pkg.sv
// Shared constants for the CPU-facing PIO blocks: register addresses and edge-capture modes.
package cpu_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd2;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, stable-count debouncer, and rise/fall pulses that
// line up with the clock edge on which the debounced value toggles.
module pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax =
        CntW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (DEBOUNCE_CYCLES == 0) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else if (sync2_q == deb_q) begin
            // Any return to the current level restarts the stability count.
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            deb_q   <= IDLE_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign rise = deb_d & ~deb_q;
    assign fall = ~deb_d & deb_q;

endmodule

// File: rtl/cpu_button_pio.sv
// Avalon-MM input PIO for the push-buttons: debounced data, irq mask and W1C edge capture
// registers, with a level interrupt to the CPU.
module cpu_button_pio
    import cpu_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_LEVEL      = 1'b1,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb, rise, fall, edge_evt;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .deb     (deb[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_evt = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_evt = fall;
        end else begin
            edge_evt = rise | fall;
        end
    end

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == PIO_ADDR_MASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // New edges are OR'd in last so they win over a same-cycle clear.
        edgecap_d = edgecap_d | edge_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA: readdata[WIDTH-1:0] = deb;
            PIO_ADDR_MASK: readdata[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGE: readdata[WIDTH-1:0] = edgecap_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
